// File: rtl/cpu_pkg.sv
// Shared opcode and sequencing-state definitions for the 16-bit RISC core.
// Imported by the hazard controller and its source-use decoder.
package cpu_pkg;

   localparam logic [4:0] OP_HALT   = 5'b00000;
   localparam logic [4:0] OP_NOP    = 5'b00001;
   localparam logic [4:0] OP_J      = 5'b00100;
   localparam logic [4:0] OP_JR     = 5'b00101;
   localparam logic [4:0] OP_JAL    = 5'b00110;
   localparam logic [4:0] OP_JALR   = 5'b00111;
   localparam logic [4:0] OP_ST     = 5'b10000;
   localparam logic [4:0] OP_LD     = 5'b10001;
   localparam logic [4:0] OP_STU    = 5'b10011;
   localparam logic [2:0] OP_BR_PFX = 3'b011;
   localparam logic [4:0] OP_LBI    = 5'b11000;
   localparam logic [4:0] OP_RTYPE  = 5'b11011;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'd0,
      HZ_STALL  = 2'd1,
      HZ_FREEZE = 2'd2,
      HZ_HALT   = 2'd3
   } hz_state_t;

endpackage

// File: rtl/src_use_decode.sv
// Combinational decode of which register sources an ID instruction reads.
// Use bits and the HALT flag are qualified by the instruction-valid input.
module src_use_decode
   import cpu_pkg::*;
#(
   parameter int REG_AW = 3
) (
   input  logic [15:0]       i_instr,
   input  logic              i_valid,
   output logic              o_use_rs,
   output logic              o_use_rt,
   output logic [REG_AW-1:0] o_rs,
   output logic [REG_AW-1:0] o_rt,
   output logic              o_is_halt
);

   logic [4:0] w_op;
   logic       w_rs_none;
   logic       w_rt_used;
   logic       w_unused_bits;

   assign w_op = i_instr[15:11];

   // Opcodes with no rs read: HALT, NOP, reserved 0001x, J, JAL, LBI
   assign w_rs_none = (w_op == OP_HALT) || (w_op == OP_NOP)
                   || (w_op == 5'b00010) || (w_op == 5'b00011)
                   || (w_op == OP_J) || (w_op == OP_JAL)
                   || (w_op == OP_LBI);

   assign w_rt_used = (w_op == OP_RTYPE) || (w_op == 5'b11010)
                   || (w_op[4:2] == 3'b111)
                   || (w_op == OP_ST) || (w_op == OP_STU);

   assign o_use_rs  = i_valid && !w_rs_none;
   assign o_use_rt  = i_valid && w_rt_used;
   assign o_rs      = i_instr[8 +: REG_AW];
   assign o_rt      = i_instr[5 +: REG_AW];
   assign o_is_halt = i_valid && (w_op == OP_HALT);

   assign w_unused_bits = ^i_instr[4:0];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/freeze/halt sequencer for the 5-stage core.
// Define HAZARD_FWD_EN when EX/MEM forwarding paths are present.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       id_instr,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_wr_en,
   input  logic              ex_redirect,
   input  logic              mem_busy,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              pipe_freeze,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt
);

   hz_state_t         r_state;
   hz_state_t         w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_use_rs;
   logic              w_use_rt;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic              w_is_halt;
   logic              w_raw_ex;
   logic              w_raw_mem;
   logic              w_haz;
   logic              w_pc_en;
   logic              w_ifid_en;
   logic              w_flush;
   logic              w_bubble;
   logic              w_freeze;

   src_use_decode #(.REG_AW(REG_AW)) u_dec (
      .i_instr   (id_instr),
      .i_valid   (id_valid),
      .o_use_rs  (w_use_rs),
      .o_use_rt  (w_use_rt),
      .o_rs      (w_rs),
      .o_rt      (w_rt),
      .o_is_halt (w_is_halt)
   );

   assign w_raw_ex  = ex_wr_en
                   && ((w_use_rs && (ex_rd == w_rs))
                    || (w_use_rt && (ex_rd == w_rt)));
   assign w_raw_mem = mem_wr_en
                   && ((w_use_rs && (mem_rd == w_rs))
                    || (w_use_rt && (mem_rd == w_rt)));

`ifdef HAZARD_FWD_EN
   logic w_unused_mem;
   assign w_haz        = ex_is_load && w_raw_ex;
   assign w_unused_mem = w_raw_mem;
`else
   logic w_unused_ld;
   assign w_haz       = w_raw_ex || w_raw_mem;
   assign w_unused_ld = ex_is_load;
`endif

   always_comb begin
      w_next    = r_state;
      w_pc_en   = 1'b1;
      w_ifid_en = 1'b1;
      w_flush   = 1'b0;
      w_bubble  = 1'b0;
      w_freeze  = 1'b0;
      if (r_state == HZ_HALT) begin
         w_pc_en   = 1'b0;
         w_ifid_en = 1'b0;
         w_bubble  = 1'b1;
      end else if (mem_busy) begin
         w_next    = HZ_FREEZE;
         w_pc_en   = 1'b0;
         w_ifid_en = 1'b0;
         w_freeze  = 1'b1;
      end else if (ex_redirect) begin
         // Redirect discards the younger ID instruction, so no stall
         w_next   = HZ_RUN;
         w_flush  = 1'b1;
         w_bubble = 1'b1;
      end else if (w_haz) begin
         w_next    = HZ_STALL;
         w_pc_en   = 1'b0;
         w_ifid_en = 1'b0;
         w_bubble  = 1'b1;
      end else if (w_is_halt) begin
         w_next    = HZ_HALT;
         w_pc_en   = 1'b0;
         w_ifid_en = 1'b0;
         w_bubble  = 1'b1;
      end else begin
         w_next = HZ_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= HZ_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (!w_pc_en && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign pc_en       = w_pc_en;
   assign ifid_en     = w_ifid_en;
   assign ifid_flush  = w_flush;
   assign idex_bubble = w_bubble;
   assign pipe_freeze = w_freeze;
   assign halted      = (r_state == HZ_HALT);
   assign stall_cnt   = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Expectations follow HAZARD_FWD_EN when the bench is built with it.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] id_instr;
   logic        id_valid;
   logic [2:0]  ex_rd;
   logic        ex_wr_en;
   logic        ex_is_load;
   logic [2:0]  mem_rd;
   logic        mem_wr_en;
   logic        ex_redirect;
   logic        mem_busy;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        pipe_freeze;
   logic        halted;
   logic [15:0] stall_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   logic [15:0] exp_cnt;

`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze}
   localparam logic [4:0] V_RUN    = 5'b11000;
   localparam logic [4:0] V_STALL  = 5'b00010;
   localparam logic [4:0] V_FREEZE = 5'b00001;

   localparam logic [15:0] I_ADD  = {5'b11011, 3'd1, 3'd3, 3'd2, 2'd0};
   localparam logic [15:0] I_HALT = 16'h0000;

   logic [4:0] vec;
   assign vec = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze};

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(16), .REG_AW(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_instr    (id_instr),
      .id_valid    (id_valid),
      .ex_rd       (ex_rd),
      .ex_wr_en    (ex_wr_en),
      .ex_is_load  (ex_is_load),
      .mem_rd      (mem_rd),
      .mem_wr_en   (mem_wr_en),
      .ex_redirect (ex_redirect),
      .mem_busy    (mem_busy),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .ifid_flush  (ifid_flush),
      .idex_bubble (idex_bubble),
      .pipe_freeze (pipe_freeze),
      .halted      (halted),
      .stall_cnt   (stall_cnt)
   );

   task automatic idle();
      id_instr    = 16'h0800;
      id_valid    = 1'b0;
      ex_rd       = 3'd0;
      ex_wr_en    = 1'b0;
      ex_is_load  = 1'b0;
      mem_rd      = 3'd0;
      mem_wr_en   = 1'b0;
      ex_redirect = 1'b0;
      mem_busy    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #12;
      n_chk++;
      if (vec !== V_RUN) begin
         n_fail++;
         $display("FAIL reset_vec got %b want %b", vec, V_RUN);
      end
      n_chk++;
      if (halted !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_halted got %b want 0", halted);
      end
      n_chk++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt got %0d want 0", stall_cnt);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 16'd0;
   endtask

   task automatic test_load_use();
      logic [4:0] want;
      @(negedge clk);
      id_instr = I_ADD; id_valid = 1'b1;
      ex_rd = 3'd1; ex_wr_en = 1'b1; ex_is_load = 1'b1;
      #2;
      n_chk++;
      if (vec !== V_STALL) begin
         n_fail++;
         $display("FAIL lu_c1 got %b want %b", vec, V_STALL);
      end
      @(negedge clk);
      ex_rd = 3'd0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
      mem_rd = 3'd1; mem_wr_en = 1'b1;
      #2;
      want = FWD ? V_RUN : V_STALL;
      n_chk++;
      if (vec !== want) begin
         n_fail++;
         $display("FAIL lu_c2 got %b want %b", vec, want);
      end
      @(negedge clk);
      idle();
      exp_cnt = exp_cnt + (FWD ? 16'd1 : 16'd2);
      #2;
      n_chk++;
      if (vec !== V_RUN) begin
         n_fail++;
         $display("FAIL lu_c3 got %b want %b", vec, V_RUN);
      end
      n_chk++;
      if (stall_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL lu_cnt got %0d want %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_redirect();
      @(negedge clk);
      id_instr = I_ADD; id_valid = 1'b1;
      ex_rd = 3'd1; ex_wr_en = 1'b1; ex_is_load = 1'b1;
      ex_redirect = 1'b1;
      #2;
      n_chk++;
      if ({pc_en, ifid_flush, idex_bubble, pipe_freeze} !== 4'b1110) begin
         n_fail++;
         $display("FAIL redir_c1 got %b want 1110",
                  {pc_en, ifid_flush, idex_bubble, pipe_freeze});
      end
      @(negedge clk);
      idle();
      #2;
      n_chk++;
      if (vec !== V_RUN) begin
         n_fail++;
         $display("FAIL redir_c2 got %b want %b", vec, V_RUN);
      end
      n_chk++;
      if (stall_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL redir_cnt got %0d want %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_freeze();
      @(negedge clk);
      id_instr = I_ADD; id_valid = 1'b1;
      ex_rd = 3'd1; ex_wr_en = 1'b1; ex_is_load = 1'b1;
      mem_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         #2;
         n_chk++;
         if (vec !== V_FREEZE) begin
            n_fail++;
            $display("FAIL frz_c%0d got %b want %b", i, vec, V_FREEZE);
         end
      end
      @(negedge clk);
      mem_busy = 1'b0;
      #2;
      n_chk++;
      if (vec !== V_STALL) begin
         n_fail++;
         $display("FAIL frz_resume got %b want %b", vec, V_STALL);
      end
      @(negedge clk);
      ex_rd = 3'd0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
      mem_rd = 3'd1; mem_wr_en = 1'b1;
      if (FWD) id_valid = 1'b0;
      #2;
      n_chk++;
      if (vec !== (FWD ? V_RUN : V_STALL)) begin
         n_fail++;
         $display("FAIL frz_mem got %b want %b", vec,
                  FWD ? V_RUN : V_STALL);
      end
      @(negedge clk);
      idle();
      exp_cnt = exp_cnt + (FWD ? 16'd6 : 16'd7);
      #2;
      n_chk++;
      if (stall_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL frz_cnt got %0d want %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_src_use();
      logic [15:0] t_instr [7];
      logic        t_valid [7];
      logic [2:0]  t_rd    [7];
      logic [4:0]  t_want  [7];
      t_instr = '{{5'b00100, 3'd4, 8'h00},
                  {5'b11000, 3'd6, 8'h12},
                  {5'b10000, 3'd2, 3'd5, 5'd0},
                  I_ADD,
                  {5'b01100, 3'd7, 8'h04},
                  I_ADD,
                  {5'b10001, 3'd2, 3'd5, 5'd0}};
      t_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      t_rd    = '{3'd4, 3'd6, 3'd5, 3'd3, 3'd7, 3'd1, 3'd5};
      t_want  = '{V_RUN, V_RUN, V_STALL, V_STALL, V_STALL, V_RUN, V_RUN};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         id_instr = t_instr[i]; id_valid = t_valid[i];
         ex_rd = t_rd[i]; ex_wr_en = 1'b1; ex_is_load = 1'b1;
         #2;
         n_chk++;
         if (vec !== t_want[i]) begin
            n_fail++;
            $display("FAIL src_v%0d got %b want %b", i, vec, t_want[i]);
         end
      end
      @(negedge clk);
      idle();
      exp_cnt = exp_cnt + 16'd3;
      #2;
      n_chk++;
      if (stall_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL src_cnt got %0d want %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_halt();
      @(negedge clk);
      id_instr = I_HALT; id_valid = 1'b1;
      #2;
      n_chk++;
      if (vec !== V_STALL || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_c0 got %b/%b want %b/0", vec, halted, V_STALL);
      end
      @(negedge clk);
      n_chk++;
      if (halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_set got %b want 1", halted);
      end
      id_valid = 1'b0; ex_redirect = 1'b1;
      #2;
      n_chk++;
      if (pc_en !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_redir_pc got %b want 0", pc_en);
      end
      @(negedge clk);
      ex_redirect = 1'b0;
      exp_cnt = exp_cnt + 16'd2;
      n_chk++;
      if (halted !== 1'b1 || stall_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL halt_sticky got %b/%0d want 1/%0d",
                  halted, stall_cnt, exp_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (halted !== 1'b0 || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL halt_async_rst got %b/%0d want 0/0",
                  halted, stall_cnt);
      end
      @(negedge clk);
      idle();
      rst_n   = 1'b1;
      exp_cnt = 16'd0;
   endtask

   task automatic test_saturate();
      @(negedge clk);
      id_instr = I_HALT; id_valid = 1'b1;
      repeat (65534) @(negedge clk);
      n_chk++;
      if (stall_cnt !== 16'hFFFE) begin
         n_fail++;
         $display("FAIL sat_pre got %h want fffe", stall_cnt);
      end
      @(negedge clk);
      n_chk++;
      if (stall_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_hit got %h want ffff", stall_cnt);
      end
      repeat (2) @(negedge clk);
      n_chk++;
      if (stall_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_hold got %h want ffff", stall_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_freeze();
      test_src_use();
      test_halt();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
